// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter between instruction fetch and the MEM stage.
package mem_arbiter_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port fixed-latency memory arbiter: MEM-stage accesses win, IF is served from DONE
// so it is never starved; returns read data with a one-cycle ready pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_ce,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_req_if,
    output logic              stall_req_mem
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              grant_if, grant_d, capture;

    // Next-state: grant selection, latency countdown and capture strobe
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_req) begin
                    grant_d = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Owner still holds its request while ready is high, so only the other side is eligible
                state_d = ST_IDLE;
                if (owner_q == OWN_D && if_req) begin
                    grant_if = 1'b1;
                end else if (owner_q == OWN_IF && d_req) begin
                    grant_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant_d || grant_if) begin
            state_d = ST_ACCESS;
            cnt_d   = CNT_LOAD;
            owner_d = grant_d ? OWN_D : OWN_IF;
        end
    end

    // State, request latch and read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_IF;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                we_q    <= d_we;
            end else if (grant_if) begin
                addr_q  <= if_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end
            if (capture && owner_q == OWN_IF) begin
                if_rdata <= m_rdata;
            end
            if (capture && owner_q == OWN_D && !we_q) begin
                d_rdata <= m_rdata;
            end
        end
    end

    assign m_ce    = (state_q == ST_ACCESS);
    assign m_we    = m_ce & we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    assign if_ready = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign d_ready  = (state_q == ST_DONE) && (owner_q == OWN_D);

    assign stall_req_if  = if_req & ~if_ready;
    assign stall_req_mem = d_req & ~d_ready;

endmodule
